// File: rtl/sw_debounce4_if.sv
// sw_debounce4_if: raw switch bus in, debounced levels, edge pulses and one-hot qualifier out
interface sw_debounce4_if #(
  parameter int N_SW = 4
);
  logic [N_SW-1:0] sw_raw;
  logic [N_SW-1:0] sw_db;
  logic [N_SW-1:0] sw_rise;
  logic [N_SW-1:0] sw_fall;
  logic            sw_onehot;
  modport master (output sw_raw, input sw_db, sw_rise, sw_fall, sw_onehot);
  modport slave  (input sw_raw, output sw_db, sw_rise, sw_fall, sw_onehot);
endinterface

// File: rtl/sw_debounce4.sv
// sw_debounce4: two-flop synchroniser plus independent per-bit debounce with rise/fall pulses
module sw_debounce4 #(
  parameter  int N_SW            = 4,
  parameter  int DEBOUNCE_CYCLES = 500000,
  localparam int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
  input logic           clk,
  input logic           key,
  sw_debounce4_if.slave bus
);
  typedef enum logic {IDLE, COUNT} state_t;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  logic [N_SW-1:0]  sync1, sync2;
  logic [N_SW-1:0]  db, rise, fall;
  logic [N_SW-1:0]  db_nx, rise_nx, fall_nx;
  state_t           state [N_SW];
  state_t           state_nx [N_SW];
  logic [CNT_W-1:0] cnt [N_SW];
  logic [CNT_W-1:0] cnt_nx [N_SW];

  // per bit: count while the synchronised level differs from db, any agreement restarts from 0
  always_comb begin
    db_nx   = db;
    rise_nx = '0;
    fall_nx = '0;
    for (int i = 0; i < N_SW; i++) begin
      state_nx[i] = state[i];
      cnt_nx[i]   = cnt[i];
      if (sync2[i] == db[i]) begin
        state_nx[i] = IDLE;
        cnt_nx[i]   = '0;
      end else if (state[i] == IDLE) begin
        state_nx[i] = COUNT;
        cnt_nx[i]   = CNT_W'(1);
      end else if (cnt[i] == LAST) begin
        state_nx[i] = IDLE;
        cnt_nx[i]   = '0;
        db_nx[i]    = sync2[i];
        rise_nx[i]  = sync2[i];
        fall_nx[i]  = ~sync2[i];
      end else begin
        cnt_nx[i]   = cnt[i] + CNT_W'(1);
      end
    end
  end

  // synchroniser, debounce state and registered outputs; key clears all progress asynchronously
  always_ff @(posedge clk or negedge key) begin
    if (!key) begin
      sync1 <= '0;
      sync2 <= '0;
      db    <= '0;
      rise  <= '0;
      fall  <= '0;
      for (int i = 0; i < N_SW; i++) begin
        state[i] <= IDLE;
        cnt[i]   <= '0;
      end
    end else begin
      sync1 <= bus.sw_raw;
      sync2 <= sync1;
      db    <= db_nx;
      rise  <= rise_nx;
      fall  <= fall_nx;
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  assign bus.sw_db     = db;
  assign bus.sw_rise   = rise;
  assign bus.sw_fall   = fall;
  assign bus.sw_onehot = (db != '0) && ((db & (db - N_SW'(1))) == '0);
endmodule

// File: tb/tb_sw_debounce4.sv
// tb_sw_debounce4: table-driven per-cycle vectors checked through an expected-value queue
module tb_sw_debounce4;
  typedef struct {
    logic       k;
    logic [3:0] raw;
    int         n;
    logic [3:0] db, rise, fall;
    logic       oh;
  } vec_t;
  typedef struct {
    string      name;
    logic [3:0] db, rise, fall;
    logic       oh;
  } exp_t;

  logic clk = 1'b0;
  logic key = 1'b1;
  int   tests = 0;
  int   fails = 0;
  vec_t tbl[$];
  exp_t sb[$];

  sw_debounce4_if #(.N_SW(4)) bus ();
  sw_debounce4 #(.N_SW(4), .DEBOUNCE_CYCLES(4)) dut (.clk(clk), .key(key), .bus(bus));

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic add(input logic k, input logic [3:0] raw, input int n,
                     input logic [3:0] db, input logic [3:0] rise, input logic [3:0] fall, input logic oh);
    tbl.push_back('{k, raw, n, db, rise, fall, oh});
  endtask

  task automatic check();
    exp_t e;
    tests++;
    if (sb.size() == 0) begin
      fails++;
      $display("FAIL scoreboard: no expected entry queued");
    end else begin
      e = sb.pop_front();
      if ({bus.sw_db, bus.sw_rise, bus.sw_fall, bus.sw_onehot} !== {e.db, e.rise, e.fall, e.oh}) begin
        fails++;
        $display("FAIL %s: got db=%b rise=%b fall=%b onehot=%b, want db=%b rise=%b fall=%b onehot=%b",
                 e.name, bus.sw_db, bus.sw_rise, bus.sw_fall, bus.sw_onehot, e.db, e.rise, e.fall, e.oh);
      end
    end
  endtask

  task automatic step(input string name, input logic k, input logic [3:0] raw,
                      input logic [3:0] db, input logic [3:0] rise, input logic [3:0] fall, input logic oh);
    key = k;
    bus.sw_raw = raw;
    sb.push_back('{name, db, rise, fall, oh});
    @(posedge clk);
    #1;
    check();
  endtask

  initial begin
    bus.sw_raw = 4'b1111;
    #2 key = 1'b0;
    #1;
    sb.push_back('{"reset_async", 4'b0, 4'b0, 4'b0, 1'b0});
    check();
    add(0, 4'hF, 3, 4'h0, 4'h0, 4'h0, 0);
    add(1, 4'hF, 5, 4'h0, 4'h0, 4'h0, 0);
    add(1, 4'hF, 1, 4'hF, 4'hF, 4'h0, 0);
    add(1, 4'hF, 2, 4'hF, 4'h0, 4'h0, 0);
    add(1, 4'h0, 5, 4'hF, 4'h0, 4'h0, 0);
    add(1, 4'h0, 1, 4'h0, 4'h0, 4'hF, 0);
    add(1, 4'h0, 2, 4'h0, 4'h0, 4'h0, 0);
    add(1, 4'h1, 5, 4'h0, 4'h0, 4'h0, 0);
    add(1, 4'h1, 1, 4'h1, 4'h1, 4'h0, 1);
    add(1, 4'h1, 2, 4'h1, 4'h0, 4'h0, 1);
    add(1, 4'h0, 5, 4'h1, 4'h0, 4'h0, 1);
    add(1, 4'h0, 1, 4'h0, 4'h0, 4'h1, 0);
    add(1, 4'h0, 2, 4'h0, 4'h0, 4'h0, 0);
    for (int j = 0; j < 5; j++) begin
      add(1, 4'h2, 2, 4'h0, 4'h0, 4'h0, 0);
      add(1, 4'h0, 2, 4'h0, 4'h0, 4'h0, 0);
    end
    add(1, 4'h0, 4, 4'h0, 4'h0, 4'h0, 0);
    add(1, 4'h4, 3, 4'h0, 4'h0, 4'h0, 0);
    add(1, 4'h0, 6, 4'h0, 4'h0, 4'h0, 0);
    add(1, 4'h4, 4, 4'h0, 4'h0, 4'h0, 0);
    add(1, 4'h0, 1, 4'h0, 4'h0, 4'h0, 0);
    add(1, 4'h0, 1, 4'h4, 4'h4, 4'h0, 1);
    add(1, 4'h0, 3, 4'h4, 4'h0, 4'h0, 1);
    add(1, 4'h0, 1, 4'h0, 4'h0, 4'h4, 0);
    add(1, 4'h0, 2, 4'h0, 4'h0, 4'h0, 0);
    add(1, 4'h6, 5, 4'h0, 4'h0, 4'h0, 0);
    add(1, 4'h6, 1, 4'h6, 4'h6, 4'h0, 0);
    add(1, 4'h6, 2, 4'h6, 4'h0, 4'h0, 0);
    foreach (tbl[i])
      for (int r = 0; r < tbl[i].n; r++)
        step($sformatf("vec%0d.%0d", i, r), tbl[i].k, tbl[i].raw, tbl[i].db, tbl[i].rise, tbl[i].fall, tbl[i].oh);
    for (int r = 0; r < 4; r++)
      step($sformatf("midcnt_pre.%0d", r), 1, 4'h7, 4'h6, 4'h0, 4'h0, 0);
    #2 key = 1'b0;
    #1;
    sb.push_back('{"midcnt_async_reset", 4'h0, 4'h0, 4'h0, 1'b0});
    check();
    #1 key = 1'b1;
    for (int r = 0; r < 5; r++)
      step($sformatf("midcnt_wait.%0d", r), 1, 4'h7, 4'h0, 4'h0, 4'h0, 0);
    step("midcnt_set", 1, 4'h7, 4'h7, 4'h7, 4'h0, 0);
    step("midcnt_hold", 1, 4'h7, 4'h7, 4'h0, 4'h0, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
